// File: rtl/screen_writer.sv
// Character-stream front end for the 80x25 text screen RAM: turns accepted bytes
// into single-cycle RAM writes and keeps a hardware cursor.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | accepting bytes; clear_i or FF starts a full clear
// ST_CLR_ROW | writing FILL across row cursor_y, columns 0..COLS-1
// ST_CLR_ALL | writing FILL to every visible cell, row-major
module screen_writer #(
  parameter int         COLS = 80,
  parameter int         ROWS = 25,
  parameter logic [7:0] FILL = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        clear_i,
  output logic [11:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        wr_en_o,
  output logic [6:0]  cursor_x_o,
  output logic [4:0]  cursor_y_o,
  output logic        busy_o
);

  localparam logic [6:0] LP_LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LP_LAST_ROW = 5'(ROWS - 1);

  localparam logic [7:0] LP_CH_BS = 8'h08;
  localparam logic [7:0] LP_CH_LF = 8'h0A;
  localparam logic [7:0] LP_CH_FF = 8'h0C;
  localparam logic [7:0] LP_CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLR_ROW = 2'd1,
    ST_CLR_ALL = 2'd2
  } state_t;

  state_t      r_state;
  logic [6:0]  r_cx;
  logic [4:0]  r_cy;
  logic [6:0]  r_clr_col;
  logic [4:0]  r_clr_row;
  logic        r_wr_en;
  logic [11:0] r_wr_addr;
  logic [7:0]  r_wr_data;

  state_t      w_state_nxt;
  logic [6:0]  w_cx_nxt;
  logic [4:0]  w_cy_nxt;
  logic [6:0]  w_clr_col_nxt;
  logic [4:0]  w_clr_row_nxt;
  logic        w_wr_en_nxt;
  logic [11:0] w_wr_addr_nxt;
  logic [7:0]  w_wr_data_nxt;

  logic        w_accept;
  logic        w_printable;
  logic [4:0]  w_cy_adv;
  logic [6:0]  w_cx_dec;

  assign ready_o     = (r_state == ST_IDLE) & ~clear_i;
  assign busy_o      = (r_state != ST_IDLE);
  assign w_accept    = ready_o & valid_i;
  assign w_printable = (char_i >= 8'h20) && (char_i <= 8'h7E);
  // Rows wrap instead of scrolling.
  assign w_cy_adv    = (r_cy == LP_LAST_ROW) ? 5'd0 : r_cy + 5'd1;
  assign w_cx_dec    = r_cx - 7'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_cx_nxt      = r_cx;
    w_cy_nxt      = r_cy;
    w_clr_col_nxt = r_clr_col;
    w_clr_row_nxt = r_clr_row;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;

    unique case (r_state)
      ST_IDLE: begin
        if (clear_i) begin
          w_state_nxt   = ST_CLR_ALL;
          w_cx_nxt      = 7'd0;
          w_cy_nxt      = 5'd0;
          w_clr_col_nxt = 7'd0;
          w_clr_row_nxt = 5'd0;
        end else if (w_accept) begin
          unique case (char_i)
            LP_CH_LF: begin
              w_cx_nxt      = 7'd0;
              w_cy_nxt      = w_cy_adv;
              w_clr_col_nxt = 7'd0;
              w_state_nxt   = ST_CLR_ROW;
            end
            LP_CH_CR: begin
              w_cx_nxt = 7'd0;
            end
            LP_CH_BS: begin
              if (r_cx != 7'd0) begin
                w_cx_nxt      = w_cx_dec;
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = {r_cy, w_cx_dec};
                w_wr_data_nxt = FILL;
              end
            end
            LP_CH_FF: begin
              w_state_nxt   = ST_CLR_ALL;
              w_cx_nxt      = 7'd0;
              w_cy_nxt      = 5'd0;
              w_clr_col_nxt = 7'd0;
              w_clr_row_nxt = 5'd0;
            end
            default: begin
              if (w_printable) begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = {r_cy, r_cx};
                w_wr_data_nxt = char_i;
                if (r_cx < LP_LAST_COL) begin
                  w_cx_nxt = r_cx + 7'd1;
                end else begin
                  w_cx_nxt      = 7'd0;
                  w_cy_nxt      = w_cy_adv;
                  w_clr_col_nxt = 7'd0;
                  w_state_nxt   = ST_CLR_ROW;
                end
              end
            end
          endcase
        end
      end

      ST_CLR_ROW: begin
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = {r_cy, r_clr_col};
        w_wr_data_nxt = FILL;
        if (r_clr_col == LP_LAST_COL) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_clr_col_nxt = r_clr_col + 7'd1;
        end
      end

      ST_CLR_ALL: begin
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = {r_clr_row, r_clr_col};
        w_wr_data_nxt = FILL;
        // Column counter wraps at COLS-1 so addresses with col >= COLS never appear.
        if (r_clr_col == LP_LAST_COL) begin
          w_clr_col_nxt = 7'd0;
          if (r_clr_row == LP_LAST_ROW) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_clr_row_nxt = r_clr_row + 5'd1;
          end
        end else begin
          w_clr_col_nxt = r_clr_col + 7'd1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cx      <= 7'd0;
      r_cy      <= 5'd0;
      r_clr_col <= 7'd0;
      r_clr_row <= 5'd0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 12'd0;
      r_wr_data <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cx      <= w_cx_nxt;
      r_cy      <= w_cy_nxt;
      r_clr_col <= w_clr_col_nxt;
      r_clr_row <= w_clr_row_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
    end
  end

  assign wr_en_o    = r_wr_en;
  assign wr_addr_o  = r_wr_addr;
  assign wr_data_o  = r_wr_data;
  assign cursor_x_o = r_cx;
  assign cursor_y_o = r_cy;

endmodule

// File: doc/screen_writer.md
# screen_writer

Character-stream front end that writes into the 80x25 text screen RAM scanned by the VGA text-mode display. It accepts ASCII bytes over a valid/ready handshake and maintains a hardware cursor. It converts printable characters and a small set of control codes into write cycles on the screen RAM write port: `address`, `data` and `wren`. The display side continues to read the same RAM with the identical address layout.

## Interface
Parameters:
- `COLS`, 80: visible columns per row.
- `ROWS`, 25: visible rows.
- `FILL`, 8'h20: byte written to cleared cells.

Ports:
- `clk`  in  1: system clock, the same clock as the screen RAM.
- `rst`  in  1: asynchronous, active-high reset.
- `char_i`  in  8: input byte.
- `valid_i`  in  1: `char_i` is valid.
- `ready_o`  out  1: block accepts a byte this cycle. A transfer occurs on an edge where `valid_i & ready_o`.
- `clear_i`  in  1: request a full-screen clear. Sampled only in IDLE.
- `wr_addr_o`  out  12: RAM address `{row[4:0], col[6:0]}`.
- `wr_data_o`  out  8: RAM write data.
- `wr_en_o`  out  1: RAM write enable. Every asserted cycle is exactly one RAM write.
- `cursor_x_o`  out  7: current column, 0..79.
- `cursor_y_o`  out  5: current row, 0..24.
- `busy_o`  out  1: high in any state other than IDLE.

## Operation
States:
- **IDLE**
  - Inputs: `ready_o = ~clear_i`.
  - Control: `clear_i` has priority. If `clear_i` is high, go to CLR_ALL and do not accept a byte that cycle.
- **CLR_ROW**
  - Writes `FILL` to `{cursor_y, 0..COLS-1}` in ascending column order, one cell per cycle.
  - Returns to IDLE after the cell at column `COLS-1`.
- **CLR_ALL**
  - Writes `FILL` to every visible cell, row-major: row 0 cols 0..79, then row 1, and so on.
  - Addresses with col ≥ 80 are never driven.
  - Takes 2000 write cycles, then returns to IDLE with the cursor at (0,0).

Byte handling for a byte accepted in IDLE:
- **Printable 0x20–0x7E**
  - Write `char_i` at (x,y).
  - If x < 79: x ← x+1.
  - Otherwise perform a line advance.
- **0x0A LF**: perform a line advance. LF implies CR; no write at the old position.
- **0x0D CR**: x ← 0. No write.
- **0x08 BS**
  - If x > 0: x ← x−1, then write `FILL` at the new x.
  - If x = 0: no-op.
  - BS never moves to the previous row.
- **0x0C FF**: same as `clear_i`. Go to CLR_ALL.
- **All other bytes**: accepted and discarded, with no write and no cursor change.

Line advance:
1. x ← 0.
2. y ← y+1, or y ← 0 if y = 24. This is wrap-around; no scrolling.
3. Enter CLR_ROW, which clears the new row.

Width and arithmetic rules:
- Cursor arithmetic is bounded explicitly to 0..79 and 0..24. The cursor never holds values ≥ 80 or ≥ 25.

## Timing
- All outputs are registered except `ready_o` and `busy_o`, which decode from state, plus `clear_i` for `ready_o`.
- Write latency: a byte accepted at edge N gives `wr_en_o`/`wr_addr_o`/`wr_data_o` valid during the cycle after edge N.
- Cursor outputs: updated at edge N. The write address uses the pre-update cursor, except for BS, which uses the decremented x.
- Throughput: printable bytes with no line advance, CR, and BS can be accepted back-to-back, one per cycle.
- Line advance costs 80 cycles with `ready_o` low. Clearing the first new cell starts on the cycle after the triggering write/accept.
- CLR_ALL keeps `ready_o` low for 2000 cycles.
- `wr_en_o` is low in IDLE except on the single-cycle writes described above.

Reset (asynchronous, effective immediately):
- State → IDLE.
- Cursor → (0,0).
- `wr_en_o` = 0, `wr_addr_o` = 0, `wr_data_o` = 0.
- `ready_o` = 1 if `clear_i` is low; `busy_o` = 0.
- Reset during CLR_ROW/CLR_ALL aborts the clear immediately. No further writes occur and RAM contents are left partially cleared.
- Reset does not clear RAM.

## Test plan
- **Reset then "AB"**
  - Stimulus: bytes 0x41, 0x42 back-to-back.
  - Required: writes (addr 0x000, 0x41) then (0x001, 0x42) on consecutive cycles; cursor (2,0); `ready_o` high throughout.
- **Auto-wrap at end of row**
  - Stimulus: 80 printable bytes from (0,0).
  - Required: last write at addr 0x04F; then 80 `FILL` writes at 0x080..0x0CF with `ready_o` low; cursor (0,1).
- **CR, LF and BS handling**
  - Stimulus: at (5,3), send 0x0D, 0x08, 0x41, 0x08, then 0x0A.
  - Required:
    - CR → x=0, no write.
    - BS at x=0 → no write.
    - 'A' written at 0x180.
    - BS writes 0x20 at 0x180, cursor (0,3).
    - LF clears row 4 (0x200..0x24F), cursor (0,4).
- **Row wrap-around**
  - Stimulus: LF at y=24.
  - Required: cursor (0,0); row 0 cleared at 0x000..0x04F.
- **Full clear**
  - Stimulus: `clear_i` and `valid_i` both asserted in IDLE.
  - Required: byte not accepted; exactly 2000 writes of 0x20, never at col ≥ 80; last write at 0xC4F; cursor (0,0); `ready_o` returns high after the 2000th write.
- **Reset mid-CLR_ALL**
  - Stimulus: assert `rst` at write #500.
  - Required: `wr_en_o` low the same cycle; IDLE; cursor (0,0); no further writes.
